mult_hazard_ctrl: RTL and testbench
===================================

Name: mult_hazard_ctrl

Overview:
Hazard and sequencing controller for the decode/execute boundary of the 5-stage MIPS pipeline. It detects load-use hazards and branch flushes, and sequences the multi-cycle multiplier. It generates stall and flush controls for the F/D and D/E pipeline registers. While a multiply is in flight, it holds back any later multiply or HI/LO read in decode.

Parameters:
MULT_LATENCY, 32, number of BUSY cycles the multiplier needs (legal range 1..63)
CNT_W, 6, width of the latency down-counter

Ports:
CLK  input  1  clock, rising edge
reset  input  1  synchronous, active-high
start_multE  input  1  mult/multu instruction currently in E
MemReadE  input  1  load instruction in E
RtE  input  5  destination register of the load in E
RsD  input  5  source register rs of the instruction in D
RtD  input  5  source register rt of the instruction in D
mult_D  input  1  instruction in D is mult/multu
mfhilo_D  input  1  instruction in D is mfhi/mflo
branch_takenD  input  1  branch resolved taken in D
StallF  output  1  hold PC
StallD  output  1  hold F/D register
FlushD  output  1  clear F/D register
FlushE  output  1  drives D/E register CLR (bubble insert)
mult_go  output  1  one-cycle start strobe to multiplier
hilo_we  output  1  one-cycle HI/LO write strobe
mult_busy  output  1  state != IDLE
stall_cnt  output  16  saturating count of stall cycles

Behaviour:
- Reset is synchronous. It has priority over every other event, including a reset arriving mid-multiply. On reset: state=IDLE, counter=0, stall_cnt=0. Every output then evaluates to 0 provided the inputs are idle.
- FSM states: IDLE, BUSY, DONE.
  - IDLE with start_multE=1: mult_go=1 (combinational, same cycle); next state BUSY; cnt<=MULT_LATENCY-1.
  - BUSY: cnt decrements by 1 each cycle. When cnt==0, next state is DONE.
  - DONE: hilo_we=1 for exactly one cycle; next state IDLE unconditionally.
  - start_multE outside IDLE is ignored: no mult_go, state unaffected. It is prevented by the stall rule below.
- Timing for a start in cycle 0: BUSY occupies cycles 1..MULT_LATENCY, hilo_we fires in cycle MULT_LATENCY+1, and state is IDLE again in cycle MULT_LATENCY+2.
- lwstall = MemReadE & (RtE!=0) & ((RtE==RsD) | (RtE==RtD)).
- multstall = (mult_D | mfhilo_D) & (mult_busy | start_multE).
- stall = lwstall | multstall.
- StallF = StallD = FlushE = stall.
- FlushD = branch_takenD & ~stall. When a stall coincides with a taken branch, the stall wins and the branch is re-evaluated next cycle.
- stall_cnt increments on every cycle with stall=1. It saturates at 16'hFFFF.
- All outputs other than state-derived strobes are combinational from inputs and state; there is no extra latency.

Decomposition:
- Package mult_hazard_pkg holds:
  - state enum (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - MULT_LATENCY default;
  - CNT_W;
  - STALL_CNT_W=16.
- One sub-module, mult_seq_fsm, contains the FSM and down-counter. Its interface is start_multE in; mult_go, hilo_we, mult_busy out.
- Hazard equations and stall_cnt live in the top.

Test Plan:
- Load-use: MemReadE=1, RtE=5, RsD=5 for one cycle -> StallF=StallD=FlushE=1 in that cycle, stall_cnt 0->1; with RtE=0 instead -> no stall.
- Multiply sequencing (MULT_LATENCY=4): start_multE=1 in cycle 0 -> mult_go=1 in cycle 0, mult_busy=1 in cycles 1..5, hilo_we=1 only in cycle 5, IDLE in cycle 6.
- HI/LO dependency: start_multE=1 in cycle 0 and mfhilo_D=1 held -> stall=1 in cycles 0..5, stall=0 in cycle 6, stall_cnt=6.
- Branch vs stall: branch_takenD=1 with lwstall=1 -> FlushD=0, FlushE=1; next cycle with lwstall=0 -> FlushD=1, FlushE=0.
- Reset mid-multiply: reset asserted during BUSY (cnt=2) -> next cycle mult_busy=0, hilo_we never fires, stall_cnt=0.
- Saturation: force 70000 consecutive stall cycles -> stall_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/mult_hazard_pkg.sv
// Shared types and constants for the decode/execute hazard and multiply sequencing controller.
package mult_hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  localparam int MULT_LATENCY = 32;
  localparam int CNT_W        = 6;
  localparam int STALL_CNT_W  = 16;

  // Saturating increment for the stall statistics counter.
  function automatic logic [STALL_CNT_W-1:0] satInc(input logic [STALL_CNT_W-1:0] value);
    if (value == {STALL_CNT_W{1'b1}}) begin
      return value;
    end else begin
      return value + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/mult_seq_fsm.sv
// Multi-cycle multiplier sequencer: IDLE -> BUSY (latency down-count) -> DONE (HI/LO write strobe).
module mult_seq_fsm #(
  parameter int MULT_LATENCY = mult_hazard_pkg::MULT_LATENCY,
  parameter int CNT_W        = mult_hazard_pkg::CNT_W
) (
  input  logic CLK,
  input  logic reset,
  input  logic start_multE,
  output logic mult_go,
  output logic hilo_we,
  output logic mult_busy
);
  import mult_hazard_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_LATENCY - 1);

  mult_state_e      stateR, stateNextS;
  logic [CNT_W-1:0] cntR, cntNextS;

  // State and latency counter registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      stateR <= IDLE;
      cntR   <= CNT_ZERO;
    end else begin
      stateR <= stateNextS;
      cntR   <= cntNextS;
    end
  end

  // Next-state, counter update and strobes; a start outside IDLE is ignored.
  always_comb begin
    stateNextS = stateR;
    cntNextS   = cntR;
    mult_go    = 1'b0;
    hilo_we    = 1'b0;
    case (stateR)
      IDLE: begin
        if (start_multE) begin
          mult_go    = 1'b1;
          stateNextS = BUSY;
          cntNextS   = CNT_LOAD;
        end else begin
          stateNextS = IDLE;
        end
      end
      BUSY: begin
        if (cntR == CNT_ZERO) begin
          stateNextS = DONE;
        end else begin
          cntNextS = cntR - CNT_ONE;
        end
      end
      DONE: begin
        hilo_we    = 1'b1;
        stateNextS = IDLE;
      end
      default: begin
        stateNextS = IDLE;
        cntNextS   = CNT_ZERO;
      end
    endcase
  end

  assign mult_busy = (stateR != IDLE);

endmodule

// File: rtl/mult_hazard_ctrl.sv
// Decode/execute hazard controller: load-use and HI/LO stalls, branch flush, multiply sequencing.
module mult_hazard_ctrl #(
  parameter int MULT_LATENCY = mult_hazard_pkg::MULT_LATENCY,
  parameter int CNT_W        = mult_hazard_pkg::CNT_W
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start_multE,
  input  logic        MemReadE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic        mult_D,
  input  logic        mfhilo_D,
  input  logic        branch_takenD,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic        mult_go,
  output logic        hilo_we,
  output logic        mult_busy,
  output logic [15:0] stall_cnt
);
  import mult_hazard_pkg::*;

  logic                   lwStallS, multStallS, stallS;
  logic [STALL_CNT_W-1:0] stallCntR;

  mult_seq_fsm #(
    .MULT_LATENCY(MULT_LATENCY),
    .CNT_W       (CNT_W)
  ) u_seq (
    .CLK        (CLK),
    .reset      (reset),
    .start_multE(start_multE),
    .mult_go    (mult_go),
    .hilo_we    (hilo_we),
    .mult_busy  (mult_busy)
  );

  // A multiply entering E this cycle already blocks a dependent op in D.
  assign lwStallS   = MemReadE & (RtE != 5'd0) & ((RtE == RsD) | (RtE == RtD));
  assign multStallS = (mult_D | mfhilo_D) & (mult_busy | start_multE);
  assign stallS     = lwStallS | multStallS;

  assign StallF = stallS;
  assign StallD = stallS;
  assign FlushE = stallS;
  assign FlushD = branch_takenD & ~stallS;

  // Saturating count of stalled cycles.
  always_ff @(posedge CLK) begin
    if (reset) begin
      stallCntR <= {STALL_CNT_W{1'b0}};
    end else if (stallS) begin
      stallCntR <= satInc(stallCntR);
    end else begin
      stallCntR <= stallCntR;
    end
  end

  assign stall_cnt = stallCntR;

endmodule

// File: tb/tb_mult_hazard_ctrl.sv
// Self-checking bench for mult_hazard_ctrl: vector table, directed corner sequences, random vs reference model.
module tb_mult_hazard_ctrl;
  localparam int L = 4;

  logic        CLK = 1'b0;
  logic        reset, start_multE, MemReadE, mult_D, mfhilo_D, branch_takenD;
  logic [4:0]  RtE, RsD, RtD;
  logic        StallF, StallD, FlushD, FlushE, mult_go, hilo_we, mult_busy;
  logic [15:0] stall_cnt;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: multiply tracked by age since its start strobe.
  bit mActive = 1'b0;
  int mAge    = 0;
  int mCnt    = 0;

  always #5 CLK = ~CLK;

  mult_hazard_ctrl #(.MULT_LATENCY(L), .CNT_W(6)) dut (
    .CLK(CLK), .reset(reset), .start_multE(start_multE), .MemReadE(MemReadE),
    .RtE(RtE), .RsD(RsD), .RtD(RtD), .mult_D(mult_D), .mfhilo_D(mfhilo_D),
    .branch_takenD(branch_takenD), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .FlushE(FlushE), .mult_go(mult_go), .hilo_we(hilo_we), .mult_busy(mult_busy),
    .stall_cnt(stall_cnt)
  );

  wire [22:0] dutVec = {StallF, StallD, FlushD, FlushE, mult_go, hilo_we, mult_busy, stall_cnt};

  typedef struct {
    logic       memRead;
    logic [4:0] rtE, rsD, rtD;
    logic       multD, mfhiloD, branch;
    logic       expStall, expFlushD;
  } vec_t;

  vec_t vecs[10];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit modelStall();
    bit lw, ms;
    lw = MemReadE && (RtE != 5'd0) && ((RtE == RsD) || (RtE == RtD));
    ms = (mult_D || mfhilo_D) && (mActive || start_multE);
    return lw || ms;
  endfunction

  function automatic logic [22:0] modelVec();
    bit st, go, hilo;
    st   = modelStall();
    go   = !mActive && start_multE;
    hilo = mActive && (mAge == L + 1);
    return {st, st, branch_takenD && !st, st, go, hilo, mActive, 16'(mCnt)};
  endfunction

  task automatic modelAdvance();
    bit st, go;
    st = modelStall();
    go = !mActive && start_multE;
    if (reset) begin
      mActive = 1'b0; mAge = 0; mCnt = 0;
    end else begin
      if (st) mCnt = (mCnt >= 65535) ? 65535 : mCnt + 1;
      if (go) begin
        mActive = 1'b1; mAge = 1;
      end else if (mActive) begin
        mAge++;
        if (mAge > L + 1) mActive = 1'b0;
      end
    end
  endtask

  task automatic stepEdge();
    @(posedge CLK);
    modelAdvance();
    #1;
  endtask

  task automatic runCycle(input string tag);
    @(negedge CLK);
    cmp(tag, 32'(dutVec), 32'(modelVec()));
    stepEdge();
  endtask

  task automatic idleInputs();
    start_multE = 1'b0; MemReadE = 1'b0; mult_D = 1'b0; mfhilo_D = 1'b0; branch_takenD = 1'b0;
    RtE = 5'd0; RsD = 5'd0; RtD = 5'd0;
  endtask

  task automatic doReset();
    idleInputs();
    reset = 1'b1;
    stepEdge();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idleInputs();
    #1;
    doReset();
    @(negedge CLK);
    cmp("reset_state", 32'(dutVec), 32'd0);
    stepEdge();

    // Vector table: state is IDLE throughout, no multiply started.
    vecs[0] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      MemReadE = vecs[i].memRead; RtE = vecs[i].rtE; RsD = vecs[i].rsD; RtD = vecs[i].rtD;
      mult_D = vecs[i].multD; mfhilo_D = vecs[i].mfhiloD; branch_takenD = vecs[i].branch;
      @(negedge CLK);
      cmp($sformatf("vec%0d_ctrl", i), 32'({StallF, StallD, FlushE, FlushD}),
          32'({vecs[i].expStall, vecs[i].expStall, vecs[i].expStall, vecs[i].expFlushD}));
      cmp($sformatf("vec%0d_model", i), 32'(dutVec), 32'(modelVec()));
      stepEdge();
    end

    // Load-use stall count 0 -> 1.
    doReset();
    MemReadE = 1'b1; RtE = 5'd5; RsD = 5'd5;
    stepEdge();
    idleInputs();
    @(negedge CLK);
    cmp("lw_stall_cnt", 32'(stall_cnt), 32'd1);
    stepEdge();

    // Multiply sequencing.
    doReset();
    for (int k = 0; k < 8; k++) begin
      start_multE = (k == 0);
      @(negedge CLK);
      cmp($sformatf("seq_go_c%0d", k), 32'(mult_go), 32'(k == 0));
      cmp($sformatf("seq_busy_c%0d", k), 32'(mult_busy), 32'(k >= 1 && k <= L + 1));
      cmp($sformatf("seq_hilo_c%0d", k), 32'(hilo_we), 32'(k == L + 1));
      stepEdge();
    end

    // HI/LO read behind a multiply.
    doReset();
    for (int k = 0; k < 7; k++) begin
      start_multE = (k == 0); mfhilo_D = 1'b1;
      @(negedge CLK);
      cmp($sformatf("hilo_stall_c%0d", k), 32'(StallD), 32'(k <= L + 1));
      if (k == 6) cmp("hilo_stall_cnt", 32'(stall_cnt), 32'd6);
      stepEdge();
    end
    idleInputs();

    // Stall beats a taken branch; the branch flushes once the stall clears.
    doReset();
    MemReadE = 1'b1; RtE = 5'd5; RsD = 5'd5; branch_takenD = 1'b1;
    @(negedge CLK);
    cmp("br_stall_flushD", 32'(FlushD), 32'd0);
    cmp("br_stall_flushE", 32'(FlushE), 32'd1);
    stepEdge();
    MemReadE = 1'b0;
    @(negedge CLK);
    cmp("br_free_flushD", 32'(FlushD), 32'd1);
    cmp("br_free_flushE", 32'(FlushE), 32'd0);
    stepEdge();
    idleInputs();

    // Reset while BUSY with the counter at 2.
    doReset();
    for (int k = 0; k < 11; k++) begin
      start_multE = (k == 0); reset = (k == 2); mfhilo_D = 1'b1;
      @(negedge CLK);
      if (k >= 3) begin
        cmp($sformatf("rst_busy_c%0d", k), 32'(mult_busy), 32'd0);
        cmp($sformatf("rst_hilo_c%0d", k), 32'(hilo_we), 32'd0);
        cmp($sformatf("rst_cnt_c%0d", k), 32'(stall_cnt), 32'd0);
      end
      cmp($sformatf("rst_model_c%0d", k), 32'(dutVec), 32'(modelVec()));
      stepEdge();
    end
    reset = 1'b0;
    idleInputs();

    // Random stimulus against the reference model.
    doReset();
    for (int n = 0; n < 3000; n++) begin
      reset         = ($urandom_range(99) == 0);
      start_multE   = ($urandom_range(3) == 0);
      MemReadE      = $urandom_range(1);
      RtE           = 5'($urandom_range(3));
      RsD           = 5'($urandom_range(3));
      RtD           = 5'($urandom_range(3));
      mult_D        = ($urandom_range(3) == 0);
      mfhilo_D      = ($urandom_range(3) == 0);
      branch_takenD = $urandom_range(1);
      runCycle("rand");
    end
    reset = 1'b0;

    // Saturation of the stall counter.
    doReset();
    MemReadE = 1'b1; RtE = 5'd5; RsD = 5'd5;
    for (int i = 1; i <= 70000; i++) begin
      stepEdge();
      if (i == 65534 || i == 65535 || i == 70000) begin
        @(negedge CLK);
        cmp($sformatf("sat_cnt_%0d", i), 32'(stall_cnt), (i == 65534) ? 32'h0000FFFE : 32'h0000FFFF);
        cmp($sformatf("sat_model_%0d", i), 32'(dutVec), 32'(modelVec()));
      end
    end
    idleInputs();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
